// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the 16x oversampled UART receiver.
//   rx_state_e : receiver FSM states
//   OVERSAMPLE : clk cycles per bit
//   MID_TICK   : tick at which the start bit is re-checked (its middle)
//   LAST_TICK  : tick at which data and stop bits are sampled
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/rx_sync_2ff.sv
// rx_sync_2ff: two-flop synchronizer for signals asynchronous to clk.
//   clk : destination clock
//   rst : asynchronous reset, active-high; flops reset to 1 (idle line level)
//   d   : asynchronous input, N bits
//   q   : synchronized output, 2 clk latency
module rx_sync_2ff #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] sync_p0;
  logic [N-1:0] sync_p1;

  // stage 0 -> stage 1: metastability settling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_x16.sv
// uart_rx_x16: 8N1 UART receiver, clk = 16x baud.
//   clk       : 16x-baud sampling clock
//   rst       : asynchronous reset, active-high
//   terminate : synchronous abort; forces IDLE and blocks new frames while high
//   rx_in     : serial line, idle high, asynchronous to clk
//   rx_data   : last received byte (updated at every stop-bit sample)
//   rx_valid  : one-cycle pulse, good frame
//   frame_err : one-cycle pulse, stop bit sampled low
//   break_det : one-cycle pulse, all-zero data with low stop bit
//   busy      : high whenever the FSM is not IDLE
module uart_rx_x16
  import uart_rx_pkg::*;
#(
  parameter int NO_OUTPUT = 0,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 terminate,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state;
  rx_state_e            state_nxt;
  logic [3:0]           tick;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  rx_sync_2ff #(
    .N (1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; terminate overrides every transition
  always_comb begin
    state_nxt = state;
    if (terminate) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (!rx_s) state_nxt = START;
        START:     if (tick == MID_TICK) state_nxt = rx_s ? IDLE : DATA;
        DATA:      if (tick == LAST_TICK && bit_idx == LAST_BIT) state_nxt = STOP;
        STOP:      if (tick == LAST_TICK) state_nxt = rx_s ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rx_s) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Counters, shift register and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      if (terminate) begin
        tick    <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          START: begin
            if (tick == MID_TICK) begin
              tick    <= '0;
              bit_idx <= '0;
            end else begin
              tick <= tick + 4'd1;
            end
          end
          DATA: begin
            // tick wraps 15->0, so STOP is entered with tick already 0
            tick <= tick + 4'd1;
            if (tick == LAST_TICK) begin
              shift_reg[bit_idx] <= rx_s;
              bit_idx            <= bit_idx + 3'd1;
            end
          end
          STOP: begin
            tick <= tick + 4'd1;
            if (tick == LAST_TICK) begin
              rx_data <= shift_reg;
              if (rx_s) begin
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                break_det <= (shift_reg == '0);
              end
            end
          end
          default: begin
            tick    <= '0;
            bit_idx <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

`ifndef SYNTHESIS
  generate
    if (NO_OUTPUT == 0) begin : g_print
      always_ff @(posedge clk) begin
        if (rx_valid) $display("uart_rx_x16: rx '%c' (0x%02h)", rx_data, rx_data);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_uart_rx_x16.sv
module tb_uart_rx_x16;

  logic       clk = 1'b0;
  logic       rst;
  logic       terminate;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  uart_rx_x16 #(
    .NO_OUTPUT (1),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .terminate (terminate),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .break_det (break_det),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ferr;
    bit         brk;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   busy_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (!rst && (rx_valid || frame_err || break_det)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, rx_valid, frame_err, break_det}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind", {30'd0, rx_valid, frame_err},
              mon_e.is_ferr ? 32'd1 : 32'd2);
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
        check("break_det", {31'd0, break_det}, {31'd0, mon_e.brk});
        n_chk++;
        if (cyc >= mon_e.cyc - 1 && cyc <= mon_e.cyc + 1) n_pass++;
        else $display("FAIL latency: got cycle %0d required %0d +-1", cyc, mon_e.cyc);
      end
    end
  end

  // Drive the first ncyc clocks of a frame {stop, data, start}; 160 = full frame.
  task automatic drive_frame(input logic [7:0] data, input logic stop, input int ncyc);
    logic [9:0] f;
    f = {stop, data, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      rx_in = f[c / 16];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit brk);
    exp_t e;
    e.is_ferr = !stop;
    e.brk     = brk;
    e.data    = data;
    e.cyc     = cyc + 155;
    q.push_back(e);
    drive_frame(data, stop, 160);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 400;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check(name, q.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    terminate = 1'b0;
    rx_in     = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_pulses", {29'd0, rx_valid, frame_err, break_det}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle line
    busy_seen = 0;
    idle(1000);
    check("idle_busy_seen", {31'd0, busy_seen}, 32'd0);
    check("idle_rx_data", {24'd0, rx_data}, 32'd0);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    drain("drain_a5");
    check("a5_rx_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    drain("drain_b2b");
    check("b2b_rx_data", {24'd0, rx_data}, 32'h0000_00FF);

    // Start glitch: low for 4 clk only
    cnt = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      @(posedge clk);
      #1;
      if (i == 3) rx_in = 1'b1;
    end
    check("glitch_busy_1to8", {31'd0, (cnt >= 1 && cnt <= 8)}, 32'd1);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // Framing error, nonzero data; line stays low afterwards
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    drain("drain_3c");
    check("ferr_rx_data", {24'd0, rx_data}, 32'h0000_003C);
    check("ferr_wait_busy", {31'd0, busy}, 32'd1);
    idle(6);
    check("ferr_release_idle", {31'd0, busy}, 32'd0);

    // Break: line low for 12 bit times
    begin
      exp_t e;
      e.is_ferr = 1'b1;
      e.brk     = 1'b1;
      e.data    = 8'h00;
      e.cyc     = cyc + 155;
      q.push_back(e);
    end
    rx_in = 1'b0;
    repeat (192) @(posedge clk);
    #1;
    drain("drain_break");
    check("break_rx_data", {24'd0, rx_data}, 32'd0);
    check("break_wait_busy", {31'd0, busy}, 32'd1);
    idle(6);
    check("break_release_idle", {31'd0, busy}, 32'd0);
    busy_seen = 0;
    idle(200);
    check("break_single_return", {31'd0, busy_seen}, 32'd0);

    // Known byte before terminate test
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    drain("drain_c3");

    // terminate during DATA bit 3
    drive_frame(8'h81, 1'b1, 68);
    terminate = 1'b1;
    @(posedge clk);
    #1;
    check("term_idle_next", {31'd0, busy}, 32'd0);
    rx_in = 1'b1;
    idle(8);
    busy_seen = 0;
    drive_frame(8'h77, 1'b1, 160);
    idle(20);
    check("term_ignored_busy", {31'd0, busy_seen}, 32'd0);
    check("term_rx_data_kept", {24'd0, rx_data}, 32'h0000_00C3);
    terminate = 1'b0;
    idle(20);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    drain("drain_5a");
    check("post_term_rx_data", {24'd0, rx_data}, 32'h0000_005A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
